uart_baud_gen_frac: RTL and testbench

//  Parametrised baud-rate generator for the UART cores. Emits an oversampled baud tick, a

---
 rtl/uart_baud_gen_frac.sv | 141 ++++++++++++++
 tb/tb_uart_baud_gen_frac.sv | 280 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_baud_gen_frac.sv
// ----------------------------------------------------------------------------
// uart_baud_gen_frac
//
// Baud-rate generator for the UART cores. It produces an oversampled baud
// tick, a transmit bit-boundary pulse and an RX mid-bit sample pulse.
//
// How it works:
//   - A down-counter reloads with the integer divisor.
//   - A FRAC_WIDTH-bit phase accumulator stretches individual tick periods
//     by one cycle, so the average tick spacing is baud_val+1+frac/2^F.
//   - New divisors are captured into a shadow register. They become active
//     only on a bit boundary, so a frame in flight never sees a rate change.
//
// Ports:
//   clk           system clock
//   reset_n       asynchronous active-low reset
//   enable        run generator; low holds counters idle
//   baud_val      requested integer divisor
//   baud_frac     requested fractional divisor
//   cfg_update    1-cycle strobe capturing baud_val/baud_frac
//   cfg_ack       1-cycle pulse when the captured divisor became active
//   baud_clock    1-cycle tick at OS x baud
//   xmit_pulse    1-cycle pulse on the last tick of each bit period
//   rx_mid_pulse  1-cycle pulse on tick OS/2 of each bit period
// ----------------------------------------------------------------------------
module uart_baud_gen_frac #(
    parameter int CNT_WIDTH      = 13,
    parameter int FRAC_WIDTH     = 3,
    parameter int OS_LOG2        = 4,
    parameter int RESET_BAUD_VAL = 0
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  enable,
    input  logic [CNT_WIDTH-1:0]  baud_val,
    input  logic [FRAC_WIDTH-1:0] baud_frac,
    input  logic                  cfg_update,
    output logic                  cfg_ack,
    output logic                  baud_clock,
    output logic                  xmit_pulse,
    output logic                  rx_mid_pulse
);

    localparam int                   MID_INT   = (1 << (OS_LOG2 - 1)) - 1;
    localparam logic [OS_LOG2-1:0]   LAST_TICK = '1;
    localparam logic [OS_LOG2-1:0]   MID_TICK  = MID_INT[OS_LOG2-1:0];
    localparam logic [CNT_WIDTH-1:0] RESET_VAL = RESET_BAUD_VAL[CNT_WIDTH-1:0];

    // One bit wider than the divisor so act_val + carry never overflows.
    logic [CNT_WIDTH:0]    cntr;
    logic [FRAC_WIDTH-1:0] acc;
    logic [OS_LOG2-1:0]    xmit_cntr;

    logic [CNT_WIDTH-1:0]  act_val;
    logic [FRAC_WIDTH-1:0] act_frac;
    logic [CNT_WIDTH-1:0]  shadow_val;
    logic [FRAC_WIDTH-1:0] shadow_frac;
    logic                  pending;

    logic                  wrap;
    logic                  bit_end;
    logic                  apply;
    logic [FRAC_WIDTH:0]   acc_sum;
    logic [CNT_WIDTH:0]    reload;

    assign wrap    = (cntr == '0);
    assign bit_end = (xmit_cntr == LAST_TICK);
    assign apply   = wrap & bit_end & pending;

    // MSB of the sum is the carry that stretches this tick period by one cycle.
    assign acc_sum = {1'b0, acc} + {1'b0, act_frac};

    // On the apply edge the reload already uses the new divisor, with no stretch.
    assign reload  = apply ? {1'b0, shadow_val}
                           : {1'b0, act_val} + (CNT_WIDTH + 1)'(acc_sum[FRAC_WIDTH]);

    always_ff @(posedge clk or negedge reset_n) begin
        // NOTE: only control/config registers exist here, no memories, so every
        // flop gets a defined reset value, including the shadow copy.
        if (!reset_n) begin
            cntr         <= '0;
            acc          <= '0;
            xmit_cntr    <= '0;
            act_val      <= RESET_VAL;
            act_frac     <= '0;
            shadow_val   <= '0;
            shadow_frac  <= '0;
            pending      <= 1'b0;
            cfg_ack      <= 1'b0;
            baud_clock   <= 1'b0;
            xmit_pulse   <= 1'b0;
            rx_mid_pulse <= 1'b0;
        end else begin
            cfg_ack <= 1'b0;
            if (!enable) begin
                cntr         <= '0;
                acc          <= '0;
                xmit_cntr    <= '0;
                baud_clock   <= 1'b0;
                xmit_pulse   <= 1'b0;
                rx_mid_pulse <= 1'b0;
                // Idle generator: no frame to protect, so take the rate at once.
                // Any older shadow value is dropped because this one is newer.
                if (cfg_update) begin
                    act_val  <= baud_val;
                    act_frac <= baud_frac;
                    pending  <= 1'b0;
                    cfg_ack  <= 1'b1;
                end
            end else begin
                baud_clock   <= wrap;
                xmit_pulse   <= wrap & bit_end;
                rx_mid_pulse <= wrap & (xmit_cntr == MID_TICK);
                if (wrap) begin
                    cntr      <= reload;
                    xmit_cntr <= xmit_cntr + OS_LOG2'(1);
                    if (apply) begin
                        act_val  <= shadow_val;
                        act_frac <= shadow_frac;
                        acc      <= '0;
                        pending  <= 1'b0;
                        cfg_ack  <= 1'b1;
                    end else begin
                        acc <= acc_sum[FRAC_WIDTH-1:0];
                    end
                end else begin
                    cntr <= cntr - (CNT_WIDTH + 1)'(1);
                end
                // NOTE: with non-blocking assignments the last write in the block
                // wins. A strobe coinciding with an apply edge therefore re-arms
                // pending. The apply itself still takes the old shadow value.
                if (cfg_update) begin
                    shadow_val  <= baud_val;
                    shadow_frac <= baud_frac;
                    pending     <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_uart_baud_gen_frac.sv
// ----------------------------------------------------------------------------
// tb_uart_baud_gen_frac
//
// Bench for uart_baud_gen_frac. It drives directed and random stimulus and
// compares the four outputs every cycle against a tick-level reference model.
//
// The model does not count down. It schedules the absolute cycle of the next
// tick. The fractional stretch of the j-th tick after an accumulator restart
// is derived directly as floor((j+1)*f/2^F) - floor(j*f/2^F).
// ----------------------------------------------------------------------------
module tb_uart_baud_gen_frac;

    localparam int CW  = 13;
    localparam int FW  = 3;
    localparam int OSL = 4;
    localparam int OS  = 1 << OSL;
    localparam int FR  = 1 << FW;
    localparam int RST_VAL = 0;

    logic          clk;
    logic          reset_n;
    logic          enable;
    logic [CW-1:0] baud_val;
    logic [FW-1:0] baud_frac;
    logic          cfg_update;
    logic          cfg_ack;
    logic          baud_clock;
    logic          xmit_pulse;
    logic          rx_mid_pulse;

    uart_baud_gen_frac #(
        .CNT_WIDTH(CW), .FRAC_WIDTH(FW), .OS_LOG2(OSL), .RESET_BAUD_VAL(RST_VAL)
    ) dut (
        .clk(clk), .reset_n(reset_n), .enable(enable),
        .baud_val(baud_val), .baud_frac(baud_frac), .cfg_update(cfg_update),
        .cfg_ack(cfg_ack), .baud_clock(baud_clock),
        .xmit_pulse(xmit_pulse), .rx_mid_pulse(rx_mid_pulse)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Reference model state.
    int cyc = 0;
    int next_wrap, j, ticks;
    bit started;
    int m_val, m_frac, sh_val, sh_frac;
    bit m_pend;
    bit e_bc, e_xp, e_rx, e_ack;

    // Bookkeeping on observed DUT pulses.
    int last_bc = 0, last_xp = 0;
    int bc_gap = 0, xp_gap = 0, rx_after_xp = 0;
    int n_ack = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s @cyc %0d: got=%0h expected=%0h", tag, cyc, got, exp);
        end
    endtask

    task automatic model_reset();
        m_val   = RST_VAL;
        m_frac  = 0;
        m_pend  = 0;
        sh_val  = 0;
        sh_frac = 0;
        started = 0;
        {e_bc, e_xp, e_rx, e_ack} = '0;
    endtask

    task automatic model_step(input bit en, input bit upd, input int bv, input int bf);
        int pos, jm, carry;
        {e_bc, e_xp, e_rx, e_ack} = '0;
        if (!en) begin
            started = 0;
            if (upd) begin
                m_val  = bv;
                m_frac = bf;
                m_pend = 0;
                e_ack  = 1;
            end
        end else begin
            if (!started) begin
                started   = 1;
                next_wrap = cyc;
                j         = 0;
                ticks     = 0;
            end
            if (cyc == next_wrap) begin
                pos  = ticks % OS;
                e_bc = 1;
                e_xp = (pos == OS - 1);
                e_rx = (pos == OS / 2 - 1);
                if (pos == OS - 1 && m_pend) begin
                    m_val     = sh_val;
                    m_frac    = sh_frac;
                    m_pend    = 0;
                    e_ack     = 1;
                    next_wrap = cyc + m_val + 1;
                    j         = 0;
                end else begin
                    jm        = j % FR;
                    carry     = ((jm + 1) * m_frac) / FR - (jm * m_frac) / FR;
                    next_wrap = cyc + m_val + 1 + carry;
                    j++;
                end
                ticks++;
            end
            if (upd) begin
                sh_val  = bv;
                sh_frac = bf;
                m_pend  = 1;
            end
        end
        cyc++;
    endtask

    // One clock: drive at negedge, update the model at posedge, compare at next negedge.
    task automatic step(input bit en, input bit upd, input int bv, input int bf);
        logic [CW-1:0] v;
        logic [FW-1:0] f;
        v = bv[CW-1:0];
        f = bf[FW-1:0];
        enable     = en;
        cfg_update = upd;
        baud_val   = v;
        baud_frac  = f;
        @(posedge clk);
        model_step(en, upd, bv, bf);
        @(negedge clk);
        check("outs", {28'd0, baud_clock, xmit_pulse, rx_mid_pulse, cfg_ack},
                      {28'd0, e_bc, e_xp, e_rx, e_ack});
        if (baud_clock) begin
            bc_gap  = cyc - last_bc;
            last_bc = cyc;
        end
        if (xmit_pulse) begin
            xp_gap  = cyc - last_xp;
            last_xp = cyc;
        end
        if (rx_mid_pulse) rx_after_xp = cyc - last_xp;
        if (cfg_ack) n_ack++;
        cfg_update = 1'b0;
    endtask

    task automatic run(input int n, input bit en);
        for (int k = 0; k < n; k++) step(en, 0, 0, 0);
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        #1;
        check("rst_outs", {28'd0, baud_clock, xmit_pulse, rx_mid_pulse, cfg_ack}, 32'd0);
        model_reset();
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
    endtask

    // Idle-time configuration: applied directly, acked on the next cycle.
    task automatic direct_cfg(input int v, input int f);
        step(0, 1, v, f);
        step(0, 0, 0, 0);
    endtask

    initial begin
        bit found;
        reset_n    = 1'b0;
        enable     = 1'b0;
        cfg_update = 1'b0;
        baud_val   = '0;
        baud_frac  = '0;
        model_reset();
        #1;
        check("por_outs", {28'd0, baud_clock, xmit_pulse, rx_mid_pulse, cfg_ack}, 32'd0);
        @(negedge clk);
        @(negedge clk);
        reset_n = 1'b1;

        // Reset divisor: a tick every cycle, xmit every 16.
        run(40, 1);
        check("rst_val_tick_gap", bc_gap, 1);
        check("rst_val_xp_gap", xp_gap, OS);

        // val=3 frac=0.
        direct_cfg(3, 0);
        run(200, 1);
        check("v3_tick_gap", bc_gap, 4);
        check("v3_xp_gap", xp_gap, 64);
        check("v3_rx_after_xp", rx_after_xp, 32);

        // val=3 frac=4.
        run(2, 0);
        direct_cfg(3, 4);
        run(250, 1);
        check("v3f4_xp_gap", xp_gap, 72);

        // val=0 frac=1: 16 ticks take 18 cycles.
        run(2, 0);
        direct_cfg(0, 1);
        run(80, 1);
        check("v0f1_xp_gap", xp_gap, 18);

        // Running update mid-bit: val 3 -> 7 at the next boundary.
        run(2, 0);
        direct_cfg(3, 0);
        run(22, 1);
        n_ack = 0;
        step(1, 1, 7, 0);
        run(200, 1);
        check("upd_v7_tick_gap", bc_gap, 8);
        check("upd_v7_ack_count", n_ack, 1);

        // Two updates before one boundary: one ack, last value wins.
        n_ack = 0;
        step(1, 1, 5, 0);
        run(3, 1);
        step(1, 1, 9, 0);
        run(400, 1);
        check("dbl_upd_ack_count", n_ack, 1);
        check("dbl_upd_tick_gap", bc_gap, 10);

        // Update landing exactly on an apply edge stays pending one more bit.
        step(1, 1, 2, 3);
        found = 0;
        for (int k = 0; k < 3000 && !found; k++) begin
            if (started && cyc == next_wrap && ticks % OS == OS - 1 && m_pend) found = 1;
            else step(1, 0, 0, 0);
        end
        check("apply_edge_found", found, 1);
        n_ack = 0;
        step(1, 1, 4, 0);
        run(150, 1);
        check("same_edge_ack_count", n_ack, 2);
        check("same_edge_tick_gap", bc_gap, 5);

        // Enable low for 3 cycles mid-bit, with a pending update kept.
        run(13, 1);
        step(1, 1, 6, 2);
        run(3, 0);
        run(150, 1);

        // Reset with pending: outputs clear at once, no ack, reset divisor again.
        step(1, 1, 9, 0);
        run(5, 1);
        do_reset();
        n_ack = 0;
        run(60, 1);
        check("rst_pend_ack_count", n_ack, 0);
        check("rst_pend_tick_gap", bc_gap, 1);

        // Largest divisor with max fraction: second gap is stretched to 8193.
        run(2, 0);
        direct_cfg((1 << CW) - 1, FR - 1);
        run(16400, 1);
        check("max_val_tick_gap", bc_gap, (1 << CW) + 1);

        // Random traffic.
        run(2, 0);
        direct_cfg(2, 0);
        for (int k = 0; k < 4000; k++) begin
            if ($urandom_range(0, 149) == 0) begin
                int len = $urandom_range(1, 5);
                for (int m = 0; m < len; m++)
                    step(0, $urandom_range(0, 3) == 0, $urandom_range(0, 9), $urandom_range(0, FR - 1));
            end else begin
                step(1, $urandom_range(0, 39) == 0, $urandom_range(0, 9), $urandom_range(0, FR - 1));
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
